// File: rtl/xbar_core_l2_multi_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xbar_core_l2_multi_if : requester and L2 bus bundle for the crossbar |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 26
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif

interface xbar_core_l2_multi_if #(
  parameter int NUM_PORTS = 3,
  parameter int PID_BITS  = 2,
  parameter int ADDR_BITS = `MEM_ADDR_BITS,
  parameter int DATA_BITS = `MEM_DATA_BITS,
  parameter int TAG_BITS  = `MEM_TAG_BITS
);
  logic [NUM_PORTS-1:0]           req_val;
  logic [NUM_PORTS-1:0]           req_rdy;
  logic [2*NUM_PORTS-1:0]         req_rw;
  logic [NUM_PORTS*ADDR_BITS-1:0] req_addr;
  logic [NUM_PORTS*DATA_BITS-1:0] req_data;
  logic [NUM_PORTS*TAG_BITS-1:0]  req_tag;
  logic [NUM_PORTS-1:0]           resp_val;
  logic [NUM_PORTS-1:0]           resp_nack;
  logic [NUM_PORTS*DATA_BITS-1:0] resp_data;
  logic [NUM_PORTS*TAG_BITS-1:0]  resp_tag;

  logic                           mem_req_val;
  logic                           mem_req_rdy;
  logic [1:0]                     mem_req_rw;
  logic [ADDR_BITS-1:0]           mem_req_addr;
  logic [DATA_BITS-1:0]           mem_req_data;
  logic [PID_BITS+TAG_BITS-1:0]   mem_req_tag;
  logic                           mem_resp_val;
  logic                           mem_resp_nack;
  logic [DATA_BITS-1:0]           mem_resp_data;
  logic [PID_BITS+TAG_BITS-1:0]   mem_resp_tag;

  // master: the crossbar itself (serves requesters, masters the L2 port)
  modport master (
    input  req_val, req_rw, req_addr, req_data, req_tag,
    output req_rdy, resp_val, resp_nack, resp_data, resp_tag,
    output mem_req_val, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
    input  mem_req_rdy, mem_resp_val, mem_resp_nack, mem_resp_data, mem_resp_tag
  );

  modport slave (
    output req_val, req_rw, req_addr, req_data, req_tag,
    input  req_rdy, resp_val, resp_nack, resp_data, resp_tag,
    input  mem_req_val, mem_req_rw, mem_req_addr, mem_req_data, mem_req_tag,
    output mem_req_rdy, mem_resp_val, mem_resp_nack, mem_resp_data, mem_resp_tag
  );
endinterface

`default_nettype wire

// File: rtl/xbar_core_l2_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | xbar_core_l2_multi : N-port round-robin request crossbar to L2 with  |
// | store locking, one-entry request buffer and tag-routed responses.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`ifndef MEM_ADDR_BITS
`define MEM_ADDR_BITS 26
`endif
`ifndef MEM_DATA_BITS
`define MEM_DATA_BITS 128
`endif
`ifndef MEM_TAG_BITS
`define MEM_TAG_BITS 5
`endif

module xbar_core_l2_multi #(
  parameter int NUM_PORTS   = 3,
  parameter int PID_BITS    = 2,
  parameter int ADDR_BITS   = `MEM_ADDR_BITS,
  parameter int DATA_BITS   = `MEM_DATA_BITS,
  parameter int TAG_BITS    = `MEM_TAG_BITS,
  parameter int STORE_BEATS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  xbar_core_l2_multi_if.master        xbar_io,
  output logic                        route_err_o
);
  localparam int                 BW        = $clog2(STORE_BEATS + 1);
  localparam bit                 USE_LOCK  = (STORE_BEATS > 1);
  localparam logic [PID_BITS-1:0] LAST_PORT = PID_BITS'(NUM_PORTS - 1);
  localparam logic [0:0]         ST_IDLE   = 1'b0;
  localparam logic [0:0]         ST_LOCK   = 1'b1;

  logic [0:0]                   state_q, state_d;
  logic [PID_BITS-1:0]          rr_ptr_q, rr_ptr_d;
  logic [PID_BITS-1:0]          lock_port_q, lock_port_d;
  logic [BW-1:0]                beat_cnt_q, beat_cnt_d;
  logic                         val_q, val_d;
  logic [1:0]                   rw_q, rw_d;
  logic [ADDR_BITS-1:0]         addr_q, addr_d;
  logic [DATA_BITS-1:0]         data_q, data_d;
  logic [PID_BITS+TAG_BITS-1:0] tag_q, tag_d;
  logic                         route_err_q, route_err_d;

  logic                w_locked;
  logic                w_can_accept;
  logic                w_gnt_vld;
  logic [PID_BITS-1:0] w_gnt_idx;
  logic [PID_BITS-1:0] w_gnt_nxt;
  logic                w_accept;
  logic [1:0]          w_req_rw;
  logic                w_is_store;
  logic                w_last_beat;
  logic [PID_BITS-1:0] w_resp_pid;

  // ---------------- lock FSM ----------------
  always_ff @(posedge clk) begin : p_fsm_reg
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin : p_fsm_next
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (w_accept && w_is_store && USE_LOCK) state_d = ST_LOCK;
      ST_LOCK: if (w_accept && w_last_beat)            state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin : p_fsm_out
    w_locked = (state_q == ST_LOCK);
  end

  // ---------------- arbitration ----------------
  always_comb begin : p_arb
    int idx;
    idx       = 0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (w_locked) begin
      w_gnt_vld = xbar_io.req_val[lock_port_q];
      w_gnt_idx = lock_port_q;
    end else begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        idx = (int'(rr_ptr_q) + k) % NUM_PORTS;
        if (!w_gnt_vld && xbar_io.req_val[idx]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = PID_BITS'(idx);
        end
      end
    end
  end

  assign w_can_accept = !val_q || xbar_io.mem_req_rdy;
  assign w_accept     = w_gnt_vld && w_can_accept;
  assign w_req_rw     = xbar_io.req_rw[w_gnt_idx*2 +: 2];
  assign w_is_store   = w_req_rw[0];
  assign w_last_beat  = (beat_cnt_q == BW'(STORE_BEATS - 1));
  assign w_gnt_nxt    = (w_gnt_idx == LAST_PORT) ? '0 : w_gnt_idx + 1'b1;

  always_comb begin : p_rdy
    xbar_io.req_rdy = '0;
    if (w_accept) xbar_io.req_rdy[w_gnt_idx] = 1'b1;
  end

  // ---------------- request buffer and pointers ----------------
  always_comb begin : p_dp_next
    val_d       = val_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    data_d      = data_q;
    tag_d       = tag_q;
    rr_ptr_d    = rr_ptr_q;
    lock_port_d = lock_port_q;
    beat_cnt_d  = beat_cnt_q;
    if (xbar_io.mem_req_rdy) val_d = 1'b0;
    if (w_accept) begin
      val_d  = 1'b1;
      // while locked the buffer still holds a beat of this store, so rw_q is the first beat's op
      rw_d   = w_locked ? rw_q : w_req_rw;
      addr_d = xbar_io.req_addr[w_gnt_idx*ADDR_BITS +: ADDR_BITS];
      data_d = xbar_io.req_data[w_gnt_idx*DATA_BITS +: DATA_BITS];
      tag_d  = {w_gnt_idx, xbar_io.req_tag[w_gnt_idx*TAG_BITS +: TAG_BITS]};
      if (w_locked) begin
        if (w_last_beat) begin
          beat_cnt_d = '0;
          rr_ptr_d   = w_gnt_nxt;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end else if (w_is_store && USE_LOCK) begin
        lock_port_d = w_gnt_idx;
        beat_cnt_d  = BW'(1);
      end else begin
        rr_ptr_d = w_gnt_nxt;
      end
    end
  end

  assign w_resp_pid  = xbar_io.mem_resp_tag[TAG_BITS+PID_BITS-1:TAG_BITS];
  assign route_err_d = route_err_q || (xbar_io.mem_resp_val && (int'(w_resp_pid) >= NUM_PORTS));

  always_ff @(posedge clk) begin : p_dp_reg
    if (reset) begin
      val_q       <= 1'b0;
      rw_q        <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      tag_q       <= '0;
      rr_ptr_q    <= '0;
      lock_port_q <= '0;
      beat_cnt_q  <= '0;
      route_err_q <= 1'b0;
    end else begin
      val_q       <= val_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      tag_q       <= tag_d;
      rr_ptr_q    <= rr_ptr_d;
      lock_port_q <= lock_port_d;
      beat_cnt_q  <= beat_cnt_d;
      route_err_q <= route_err_d;
    end
  end

  assign xbar_io.mem_req_val  = val_q;
  assign xbar_io.mem_req_rw   = rw_q;
  assign xbar_io.mem_req_addr = addr_q;
  assign xbar_io.mem_req_data = data_q;
  assign xbar_io.mem_req_tag  = tag_q;
  assign route_err_o          = route_err_q;

  // ---------------- response routing ----------------
  always_comb begin : p_resp
    xbar_io.resp_val  = '0;
    xbar_io.resp_nack = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (int'(w_resp_pid) == k) begin
        xbar_io.resp_val[k]  = xbar_io.mem_resp_val;
        xbar_io.resp_nack[k] = xbar_io.mem_resp_nack;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_resp_bcast
      assign xbar_io.resp_data[gi*DATA_BITS +: DATA_BITS] = xbar_io.mem_resp_data;
      assign xbar_io.resp_tag[gi*TAG_BITS +: TAG_BITS]    = xbar_io.mem_resp_tag[TAG_BITS-1:0];
    end
  endgenerate
endmodule

`default_nettype wire

// File: tb/tb_xbar_core_l2_multi.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_xbar_core_l2_multi : directed self-checking bench for the crossbar|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_xbar_core_l2_multi;
  localparam int NP = 3;
  localparam int PB = 2;
  localparam int AB = 26;
  localparam int DB = 128;
  localparam int TB = 5;

  logic clk;
  logic reset;
  logic route_err;
  int   n_cmp;
  int   n_err;
  logic [DB-1:0] dbeat [4];

  xbar_core_l2_multi_if #(.NUM_PORTS(NP), .PID_BITS(PB), .ADDR_BITS(AB),
                          .DATA_BITS(DB), .TAG_BITS(TB)) bus ();

  xbar_core_l2_multi #(.NUM_PORTS(NP), .PID_BITS(PB), .ADDR_BITS(AB), .DATA_BITS(DB),
                       .TAG_BITS(TB), .STORE_BEATS(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .xbar_io    (bus.master),
    .route_err_o(route_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int p, input logic v, input logic [1:0] rw,
                       input logic [AB-1:0] addr, input logic [DB-1:0] data,
                       input logic [TB-1:0] tag);
    bus.req_val[p]             = v;
    bus.req_rw[p*2 +: 2]       = rw;
    bus.req_addr[p*AB +: AB]   = addr;
    bus.req_data[p*DB +: DB]   = data;
    bus.req_tag[p*TB +: TB]    = tag;
  endtask

  task automatic clear_inputs();
    bus.req_val       = '0;
    bus.req_rw        = '0;
    bus.req_addr      = '0;
    bus.req_data      = '0;
    bus.req_tag       = '0;
    bus.mem_req_rdy   = 1'b0;
    bus.mem_resp_val  = 1'b0;
    bus.mem_resp_nack = 1'b0;
    bus.mem_resp_data = '0;
    bus.mem_resp_tag  = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    dbeat[0] = 128'hD0;
    dbeat[1] = 128'hD1;
    dbeat[2] = 128'hD2;
    dbeat[3] = 128'hD3;
    do_reset();
    settle();
    chk("rst_req_rdy", 128'(bus.req_rdy), 128'h0);
    chk("rst_mem_val", 128'(bus.mem_req_val), 128'h0);
    chk("rst_route_err", 128'(route_err), 128'h0);

    // single load from port 1
    bus.mem_req_rdy = 1'b1;
    drive(1, 1'b1, 2'b10, 26'h40, '0, 5'd5);
    settle();
    chk("ld_req_rdy", 128'(bus.req_rdy), 128'h2);
    step();
    drive(1, 1'b0, 2'b00, '0, '0, '0);
    settle();
    chk("ld_mem_val", 128'(bus.mem_req_val), 128'h1);
    chk("ld_mem_addr", 128'(bus.mem_req_addr), 128'h40);
    chk("ld_mem_tag", 128'(bus.mem_req_tag), 128'h25);
    chk("ld_mem_rw", 128'(bus.mem_req_rw), 128'h2);
    step();
    settle();
    chk("ld_drain", 128'(bus.mem_req_val), 128'h0);

    // round robin among three continuous loaders
    do_reset();
    bus.mem_req_rdy = 1'b1;
    drive(0, 1'b1, 2'b00, 26'h100, '0, 5'd1);
    drive(1, 1'b1, 2'b00, 26'h101, '0, 5'd2);
    drive(2, 1'b1, 2'b10, 26'h102, '0, 5'd3);
    settle();
    chk("rr_rdy0", 128'(bus.req_rdy), 128'h1);
    step(); settle();
    chk("rr_rdy1", 128'(bus.req_rdy), 128'h2);
    chk("rr_tag0", 128'(bus.mem_req_tag), 128'h01);
    step(); settle();
    chk("rr_rdy2", 128'(bus.req_rdy), 128'h4);
    chk("rr_tag1", 128'(bus.mem_req_tag), 128'h22);
    step(); settle();
    chk("rr_rdy3", 128'(bus.req_rdy), 128'h1);
    chk("rr_tag2", 128'(bus.mem_req_tag), 128'h43);
    step(); settle();
    chk("rr_rdy4", 128'(bus.req_rdy), 128'h2);
    chk("rr_val4", 128'(bus.mem_req_val), 128'h1);
    step(); settle();
    chk("rr_rdy5", 128'(bus.req_rdy), 128'h4);
    chk("rr_addr4", 128'(bus.mem_req_addr), 128'h101);
    step();
    bus.req_val = '0;
    settle();
    chk("rr_addr5", 128'(bus.mem_req_addr), 128'h102);
    step();

    // 4-beat store from port 2 with port 0 waiting
    drive(2, 1'b1, 2'b01, 26'hA0, dbeat[0], 5'd4);
    settle();
    chk("st_rdy_b0", 128'(bus.req_rdy), 128'h4);
    step();
    drive(0, 1'b1, 2'b10, 26'h300, '0, 5'd6);
    drive(2, 1'b1, 2'b00, 26'hA0, dbeat[1], 5'd4);
    settle();
    chk("st_rdy_b1", 128'(bus.req_rdy), 128'h4);
    chk("st_data_b0", 128'(bus.mem_req_data), dbeat[0]);
    chk("st_tag_b0", 128'(bus.mem_req_tag), 128'h44);
    step();
    drive(2, 1'b1, 2'b00, 26'hA0, dbeat[2], 5'd4);
    settle();
    chk("st_rdy_b2", 128'(bus.req_rdy), 128'h4);
    chk("st_data_b1", 128'(bus.mem_req_data), dbeat[1]);
    chk("st_rw_b1", 128'(bus.mem_req_rw), 128'h1);
    step();
    drive(2, 1'b1, 2'b00, 26'hA0, dbeat[3], 5'd4);
    settle();
    chk("st_rdy_b3", 128'(bus.req_rdy), 128'h4);
    chk("st_data_b2", 128'(bus.mem_req_data), dbeat[2]);
    step();
    drive(2, 1'b0, 2'b00, '0, '0, '0);
    settle();
    chk("st_data_b3", 128'(bus.mem_req_data), dbeat[3]);
    chk("st_rw_b3", 128'(bus.mem_req_rw), 128'h1);
    chk("st_port0_rdy", 128'(bus.req_rdy), 128'h1);
    step();
    drive(0, 1'b0, 2'b00, '0, '0, '0);
    settle();
    chk("st_port0_addr", 128'(bus.mem_req_addr), 128'h300);
    chk("st_port0_tag", 128'(bus.mem_req_tag), 128'h06);

    // L2 stall with the buffer full
    bus.mem_req_rdy = 1'b0;
    drive(1, 1'b1, 2'b10, 26'h200, '0, 5'd3);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("stall_rdy", 128'(bus.req_rdy), 128'h0);
      chk("stall_addr", 128'(bus.mem_req_addr), 128'h300);
      chk("stall_val", 128'(bus.mem_req_val), 128'h1);
      step();
    end
    bus.mem_req_rdy = 1'b1;
    settle();
    chk("unstall_rdy", 128'(bus.req_rdy), 128'h2);
    step();
    drive(1, 1'b0, 2'b00, '0, '0, '0);
    settle();
    chk("unstall_addr", 128'(bus.mem_req_addr), 128'h200);
    chk("unstall_tag", 128'(bus.mem_req_tag), 128'h23);
    step();

    // response routing
    bus.mem_resp_val  = 1'b1;
    bus.mem_resp_tag  = 7'h47;
    bus.mem_resp_data = 128'hAB;
    bus.mem_resp_nack = 1'b0;
    settle();
    chk("resp_val_p2", 128'(bus.resp_val), 128'h4);
    chk("resp_tag_p2", 128'(bus.resp_tag[14:10]), 128'h7);
    chk("resp_data_p2", 128'(bus.resp_data[383:256]), 128'hAB);
    chk("resp_nack0", 128'(bus.resp_nack), 128'h0);
    bus.mem_resp_nack = 1'b1;
    settle();
    chk("resp_nack_p2", 128'(bus.resp_nack), 128'h4);
    bus.mem_resp_nack = 1'b0;
    bus.mem_resp_tag  = 7'h03;
    settle();
    chk("resp_val_p0", 128'(bus.resp_val), 128'h1);
    chk("resp_tag_p0", 128'(bus.resp_tag[4:0]), 128'h3);

    // out-of-range port id
    bus.mem_resp_tag = 7'h60;
    settle();
    chk("bad_pid_val", 128'(bus.resp_val), 128'h0);
    chk("bad_pid_err_pre", 128'(route_err), 128'h0);
    step();
    bus.mem_resp_val = 1'b0;
    settle();
    chk("bad_pid_err", 128'(route_err), 128'h1);
    step();
    settle();
    chk("bad_pid_sticky", 128'(route_err), 128'h1);

    // reset during second store beat
    do_reset();
    settle();
    chk("rst_clr_err", 128'(route_err), 128'h0);
    bus.mem_req_rdy = 1'b1;
    drive(1, 1'b1, 2'b01, 26'h500, 128'hE0, 5'd2);
    settle();
    chk("rs_rdy_b0", 128'(bus.req_rdy), 128'h2);
    step();
    drive(1, 1'b1, 2'b01, 26'h500, 128'hE1, 5'd2);
    reset = 1'b1;
    step();
    reset = 1'b0;
    drive(1, 1'b0, 2'b00, '0, '0, '0);
    drive(0, 1'b1, 2'b10, 26'h600, '0, 5'd1);
    settle();
    chk("rs_mem_val", 128'(bus.mem_req_val), 128'h0);
    chk("rs_unlocked", 128'(bus.req_rdy), 128'h1);
    step();
    drive(0, 1'b0, 2'b00, '0, '0, '0);
    settle();
    chk("rs_addr", 128'(bus.mem_req_addr), 128'h600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

`default_nettype wire
